// File: rtl/fp32_adder.sv
// IEEE-754 binary32 adder (round-to-nearest-even) with one output register.
// Subtraction is done by the caller flipping the sign bit of b.
module fp32_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);

  // n carries {mantissa[23:0], guard, round, sticky}; e_eff is the effective exponent.
  function automatic logic [31:0] round_pack(input logic       sgn,
                                             input logic [9:0]  e_eff,
                                             input logic [26:0] n);
    logic [24:0] m_r;
    logic        up;
    logic [9:0]  e_fld;
    up  = n[2] & (n[1] | n[0] | n[3]);
    m_r = {1'b0, n[26:3]} + {24'd0, up};
    if (m_r[24]) begin
      e_fld = e_eff + 10'd1;
      m_r   = m_r >> 1;
    end else if (m_r[23]) begin
      e_fld = e_eff;
    end else begin
      e_fld = 10'd0;
    end
    if (e_fld >= 10'd255) round_pack = {sgn, 8'hFF, 23'd0};
    else                  round_pack = {sgn, e_fld[7:0], m_r[22:0]};
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap;
  logic [31:0] big, sml;
  logic [7:0]  e_big, e_sml, d, lim;
  logic [4:0]  d_cl, lz, sh;
  logic [23:0] m_big, m_sml;
  logic [51:0] al;
  logic [26:0] big_al, sml_al, dif, n;
  logic [27:0] sum;
  logic [9:0]  e_n;
  logic [31:0] fin, s_nxt;

  always_comb begin
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);

    swap  = b[30:0] > a[30:0];
    big   = swap ? b : a;
    sml   = swap ? a : b;
    e_big = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    e_sml = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    m_big = {|big[30:23], big[22:0]};
    m_sml = {|sml[30:23], sml[22:0]};

    // Alignment: everything shifted past the round bit collapses into sticky.
    d      = e_big - e_sml;
    d_cl   = (d > 8'd26) ? 5'd26 : d[4:0];
    al     = {m_sml, 28'd0} >> d_cl;
    sml_al = {al[51:26], |al[25:0]};
    big_al = {m_big, 3'd0};

    sum = {1'b0, big_al} + {1'b0, sml_al};
    dif = big_al - sml_al;
    lz  = lzc27(dif);
    lim = e_big - 8'd1;
    sh  = ({3'd0, lz} > lim) ? lim[4:0] : lz;

    if (big[31] == sml[31]) begin
      if (sum[27]) begin
        n   = {sum[27:2], |sum[1:0]};
        e_n = {2'b00, e_big} + 10'd1;
      end else begin
        n   = sum[26:0];
        e_n = {2'b00, e_big};
      end
    end else begin
      // Left-normalise, but stop at effective exponent 1 so subnormals survive.
      n   = dif << sh;
      e_n = {2'b00, e_big} - {5'd0, sh};
    end

    if (n == 27'd0) fin = {a[31] & b[31], 31'd0};
    else            fin = round_pack(big[31], e_n, n);

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) s_nxt = 32'h7FC00000;
    else if (a_inf)                                              s_nxt = a;
    else if (b_inf)                                              s_nxt = b;
    else                                                         s_nxt = fin;
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= 32'h00000000;
    else        s <= s_nxt;
  end

endmodule

// File: tb/tb_fp32_adder.sv
// Bench for fp32_adder: directed corner cases plus randomized pairs checked
// against an exact wide-integer binary32 reference.
module tb_fp32_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] s;

  int n_tests = 0;
  int n_fail  = 0;

  fp32_adder dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .s(s));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (a=%h b=%h)", tag, got, exp, a, b);
    end
  endtask

  // Value of a finite operand in units of 2^-149 (exact, up to ~2^277).
  function automatic logic [289:0] scaled(input logic [31:0] x);
    logic [7:0]  e;
    logic [23:0] m;
    e = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    m = {|x[30:23], x[22:0]};
    return 290'(m) << (e - 8'd1);
  endfunction

  // Exact sum of two binary32 values, then one RNE rounding back to binary32.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic         xn, yn, xi, yi, sg;
    logic [289:0] mx, my, mag, keep, rem, half;
    int           p, shift, e;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    if (xn || yn) return 32'h7FC00000;
    if (xi && yi) return (x[31] == y[31]) ? x : 32'h7FC00000;
    if (xi) return x;
    if (yi) return y;
    mx = scaled(x);
    my = scaled(y);
    if (x[31] == y[31]) begin
      mag = mx + my; sg = x[31];
    end else if (mx >= my) begin
      mag = mx - my; sg = x[31];
    end else begin
      mag = my - mx; sg = y[31];
    end
    if (mag == 0) return {x[31] & y[31], 31'd0};
    p = 0;
    for (int i = 0; i < 290; i++) if (mag[i]) p = i;
    if (p <= 23) return {sg, mag[30:0]};
    shift = p - 23;
    keep  = mag >> shift;
    rem   = mag & ((290'd1 << shift) - 290'd1);
    half  = 290'd1 << (shift - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 290'd1;
    if (keep[24]) begin
      keep  = keep >> 1;
      shift = shift + 1;
    end
    e = shift + 1;
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    return {sg, 8'(e), keep[22:0]};
  endfunction

  function automatic logic [31:0] gen_op();
    logic [31:0] sp [10] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                              32'h7FC00000, 32'h7F800001, 32'h7F7FFFFF, 32'h00000001,
                              32'h007FFFFF, 32'h00800000};
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       r = sp[$urandom_range(0, 9)];
      1:       r[30:23] = 8'd0;
      2:       r[30:23] = 8'(24'($urandom_range(1, 3)));
      3:       r[30:23] = 8'(24'($urandom_range(250, 254)));
      default: ;
    endcase
    return r;
  endfunction

  // Second operand: often near the first, to provoke cancellation and ties.
  function automatic logic [31:0] gen_b(input logic [31:0] x);
    logic [31:0] r;
    int          e;
    case ($urandom_range(0, 3))
      0: r = gen_op();
      1: begin
        r = $urandom;
        e = int'(x[30:23]) + $urandom_range(0, 6) - 3;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        r[30:23] = 8'(e);
      end
      2: r = x ^ {9'd0, 23'($urandom_range(0, 7))};
      default: begin
        r = $urandom;
        e = int'(x[30:23]) - $urandom_range(20, 30);
        r[30:23] = (e < 0) ? 8'd0 : 8'(e);
      end
    endcase
    return r;
  endfunction

  logic [95:0] dir [16];
  logic [31:0] exp_prev;
  logic        have_prev;
  logic [31:0] ra, rb;

  initial begin
    dir = '{
      {32'h3F800000, 32'h40000000, 32'h40400000},
      {32'h3F800000, 32'hBF800000, 32'h00000000},
      {32'h40490FDB, 32'hC0490FDB, 32'h00000000},
      {32'h3F800000, 32'h33800000, 32'h3F800000},
      {32'h3F800001, 32'h33800000, 32'h3F800002},
      {32'h3F800000, 32'h33800001, 32'h3F800001},
      {32'h4B800000, 32'h3F800000, 32'h4B800000},
      {32'h3F800001, 32'hBF800000, 32'h34000000},
      {32'h00000001, 32'h00000001, 32'h00000002},
      {32'h00800000, 32'h80000001, 32'h007FFFFF},
      {32'h007FFFFF, 32'h00000001, 32'h00800000},
      {32'h80000000, 32'h80000000, 32'h80000000},
      {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
      {32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000},
      {32'h7F800000, 32'hFF800000, 32'h7FC00000},
      {32'h7FC00001, 32'h3F800000, 32'h7FC00000}
    };

    // Power-on reset
    a = 32'h3F800000;
    b = 32'h3F800000;
    #2 rst_n = 1'b0;
    #1 chk("reset_async", s, 32'h00000000);
    @(negedge clk);
    chk("reset_hold", s, 32'h00000000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release", s, 32'h40000000);

    // Directed vectors, one cycle latency each
    for (int i = 0; i < 16; i++) begin
      a = dir[i][95:64];
      b = dir[i][63:32];
      @(negedge clk);
      chk($sformatf("dir%0d", i), s, dir[i][31:0]);
    end
    a = 32'h7F800000;
    b = 32'h3F800000;
    @(negedge clk);
    chk("inf_plus_finite", s, 32'h7F800000);

    // Mid-run reset clears s without a clock edge
    a = 32'h3F800000;
    b = 32'h3F800000;
    #2 rst_n = 1'b0;
    #1 chk("midrun_reset", s, 32'h00000000);
    @(negedge clk);
    chk("midrun_reset_hold", s, 32'h00000000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrun_release", s, 32'h40000000);

    // Random regression, back-to-back a+b and a-b
    have_prev = 1'b0;
    exp_prev  = 32'd0;
    for (int i = 0; i < 10000; i++) begin
      ra = gen_op();
      rb = gen_b(ra);
      for (int k = 0; k < 2; k++) begin
        if (have_prev) chk("rand", s, exp_prev);
        a = ra;
        b = (k == 1) ? (rb ^ 32'h80000000) : rb;
        exp_prev  = ref_add(a, b);
        have_prev = 1'b1;
        @(negedge clk);
      end
    end
    chk("rand_last", s, exp_prev);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_adder.md
Name: fp32_adder

Overview:
- IEEE-754 binary32 adder: s = a + b, round-to-nearest-even, with full special-value handling.
- Combinational datapath with a single output register, so results appear one clock after the operands.
- Subtraction is done by the instantiating logic, which flips bit 31 of b (b ^ 0x80000000). The block has no separate subtract mode.

Parameters:
None.

Ports:
clk    input   1   rising-edge clock
rst_n  input   1   asynchronous active-low reset
a      input   32  operand A, binary32 (sign[31], exp[30:23], frac[22:0])
b      input   32  operand B, binary32
s      output  32  registered sum, binary32

Behaviour:
- Reset: rst_n low clears s to 32'h00000000 immediately, regardless of clk. Deassertion takes effect at the next rising edge.
- Latency: s on edge N+1 reflects a/b sampled at edge N. Throughput is one result per cycle. There is no handshake.
- Operands are unpacked as follows:
  - Exponent 0: subnormal, with hidden bit 0 and effective exponent 1.
  - Exponent 1..254: normal, with hidden bit 1.
  - Exponent 255: infinity if frac is 0, otherwise NaN.
- Special cases, in priority order:
  - Either operand NaN -> 32'h7FC00000 (canonical quiet NaN; payload not propagated).
  - +Inf + -Inf -> 32'h7FC00000.
  - Inf + finite, or Inf + same-signed Inf -> that Inf.
- Alignment:
  - Swap the operands so the larger magnitude (compare exp then frac) is the big operand. Result sign defaults to the big operand's sign.
  - Right-shift the small significand by the exponent difference.
  - Keep guard and round bits, and OR all bits shifted further into sticky.
  - A difference of 26 or more leaves only the sticky bit.
- Add/subtract:
  - Equal signs: add significands. On carry-out, shift right 1, exponent +1, and fold the lost bit into sticky.
  - Unequal signs: subtract small from big. Normalize left by the leading-zero count, but never below effective exponent 1, so the result may stay subtnormal.
- Rounding is round-to-nearest-even from guard/round/sticky:
  - Increment when G & (R | S | lsb).
  - A mantissa overflow after rounding renormalizes with exponent +1. This also covers subnormal-to-normal promotion, e.g. 007FFFFF + 00000001 -> 00800000.
- Exact zero result: +0 (32'h00000000) except (-0)+(-0) = 32'h80000000. This includes x + (-x) and (+0)+(-0).
- Overflow: a final exponent of 255 or more gives ±Inf (7F800000 / FF800000) with the result sign.
- Underflow: results with exponent field 0 are encoded as subnormals. There is no flush-to-zero and no exception flags.
- Output must be bit-exact to IEEE-754 RNE for every non-NaN input pair.
- The datapath is purely combinational between the input ports and the s register. No internal state other than s.

Test Plan:
- Reset: assert rst_n=0 mid-run with a=3F800000, b=3F800000 -> s=00000000 immediately. After release and one clk edge -> s=40000000.
- Basic add/sub, all results one cycle after the operands:
  - 3F800000 + 40000000 -> 40400000.
  - 3F800000 + BF800000 -> 00000000.
  - 40490FDB + C0490FDB -> 00000000.
- Rounding ties and sticky:
  - 3F800000 + 33800000 -> 3F800000 (tie, round to even).
  - 3F800001 + 33800000 -> 3F800002.
  - 3F800000 + 33800001 -> 3F800001 (sticky breaks the tie).
  - 4B800000 + 3F800000 -> 4B800000.
- Cancellation and subnormals:
  - 3F800001 + BF800000 -> 34000000.
  - 00000001 + 00000001 -> 00000002.
  - 00800000 + 80000001 -> 007FFFFF.
  - 007FFFFF + 00000001 -> 00800000.
  - 80000000 + 80000000 -> 80000000.
- Overflow and specials:
  - 7F7FFFFF + 7F7FFFFF -> 7F800000.
  - FF7FFFFF + FF7FFFFF -> FF800000.
  - 7F800000 + FF800000 -> 7FC00000.
  - 7FC00001 + 3F800000 -> 7FC00000.
  - 7F800000 + 3F800000 -> 7F800000.
- Random regression: 10000 random pairs, each driven as a+b and as a+(b^80000000) on back-to-back cycles, compared bit-exact against a software binary32 RNE model. Any NaN result must equal 7FC00000. Zero mismatches required.
